// File: rtl/dmem_lsu.sv
// Load/store unit: turns a single-cycle core memory request into a valid/ready
// bus transaction, stalls the core for its duration and returns extended load data.
module dmem_lsu #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_val,
    input  logic        req_fcn,
    input  logic [2:0]  req_typ,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        exc_misaligned,
    output logic        exc_fault,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_we,
    output logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_wdata,
    output logic [3:0]  mem_req_wstrb,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data
);
    localparam logic [2:0] MT_B  = 3'd1;
    localparam logic [2:0] MT_H  = 3'd2;
    localparam logic [2:0] MT_BU = 3'd5;
    localparam logic [2:0] MT_HU = 3'd6;
    localparam logic [7:0] TMO   = TIMEOUT[7:0];

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        valid_q, valid_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] rdata_q, rdata_d;
    logic        fault_q, fault_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  typ_q, typ_d;
    logic [1:0]  off_q, off_d;
    logic        mis_s;
    logic        start_s;
    logic [7:0]  cnt_inc_s;

    // Codes other than the byte/half variants behave as a full word.
    function automatic logic is_byte(input logic [2:0] typ);
        return (typ == MT_B) || (typ == MT_BU);
    endfunction

    function automatic logic is_half(input logic [2:0] typ);
        return (typ == MT_H) || (typ == MT_HU);
    endfunction

    function automatic logic [31:0] load_ext(input logic [31:0] data, input logic [2:0] typ,
                                             input logic [1:0] off);
        logic [31:0] sh;
        sh = data >> {off, 3'b000};
        case (typ)
            MT_B:    return {{24{sh[7]}}, sh[7:0]};
            MT_BU:   return {24'h000000, sh[7:0]};
            MT_H:    return {{16{sh[15]}}, sh[15:0]};
            MT_HU:   return {16'h0000, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    // Misalignment check and the combinational handshake back to the core.
    always_comb begin
        if (is_byte(req_typ)) begin
            mis_s = 1'b0;
        end else if (is_half(req_typ)) begin
            mis_s = req_addr[0];
        end else begin
            mis_s = (req_addr[1:0] != 2'b00);
        end
        start_s        = (state_q == S_IDLE) && req_val && !mis_s;
        exc_misaligned = (state_q == S_IDLE) && req_val && mis_s;
        stall          = start_s || (state_q == S_REQ) || (state_q == S_WAIT);
        cnt_inc_s      = cnt_q + 8'd1;
    end

    // Next-state and next-output computation for the access sequencer.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rdata_d = rdata_q;
        fault_d = fault_q;
        cnt_d   = cnt_q;
        typ_d   = typ_q;
        off_d   = off_q;
        case (state_q)
            S_IDLE: begin
                if (start_s) begin
                    state_d = S_REQ;
                    valid_d = 1'b1;
                    we_d    = req_fcn;
                    addr_d  = {req_addr[31:2], 2'b00};
                    typ_d   = req_typ;
                    off_d   = req_addr[1:0];
                    if (is_byte(req_typ)) begin
                        wdata_d = {4{req_wdata[7:0]}};
                        wstrb_d = req_fcn ? (4'b0001 << req_addr[1:0]) : 4'b0000;
                    end else if (is_half(req_typ)) begin
                        wdata_d = {2{req_wdata[15:0]}};
                        wstrb_d = req_fcn ? (4'b0011 << req_addr[1:0]) : 4'b0000;
                    end else begin
                        wdata_d = req_wdata;
                        wstrb_d = req_fcn ? 4'hF : 4'b0000;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (mem_req_ready) begin
                    state_d = S_WAIT;
                    valid_d = 1'b0;
                    cnt_d   = 8'd0;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_inc_s;
                // A response in the final timeout cycle still wins over the fault.
                if (mem_resp_valid) begin
                    state_d = S_DONE;
                    if (!we_q) begin
                        rdata_d = load_ext(mem_resp_data, typ_q, off_q);
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else if (cnt_inc_s == TMO) begin
                    state_d = S_DONE;
                    fault_d = 1'b1;
                    rdata_d = 32'h0000_0000;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                fault_d = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                fault_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0000_0000;
            wdata_q <= 32'h0000_0000;
            wstrb_q <= 4'b0000;
            rdata_q <= 32'h0000_0000;
            fault_q <= 1'b0;
            cnt_q   <= 8'd0;
            typ_q   <= 3'd0;
            off_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
            typ_q   <= typ_d;
            off_q   <= off_d;
        end
    end

    assign mem_req_valid = valid_q;
    assign mem_req_we    = we_q;
    assign mem_req_addr  = addr_q;
    assign mem_req_wdata = wdata_q;
    assign mem_req_wstrb = wstrb_q;
    assign rdata         = rdata_q;
    assign exc_fault     = fault_q;

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Load/store unit between the 1-stage datapath/control and the data-memory port. It takes the core's single-cycle memory request (ALU-computed address, rs2 store data, function, and type). It then:
- issues a word-aligned, byte-strobed request on a valid/ready memory bus;
- waits for the response;
- returns the aligned, sign- or zero-extended load data;
- holds the core stalled for the whole access.

It also flags misaligned accesses and access timeouts as exception causes for the control path.

## Interface
- `TIMEOUT`, default 255: maximum cycles spent in WAIT before an access fault is raised. Legal range is 1..255.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-low reset.
- `req_val`  in  1  core requests a memory access. Held stable while `stall`=1.
- `req_fcn`  in  1  0=load (M_XRD), 1=store (M_XWR).
- `req_typ`  in  3  MT_B=1, MT_H=2, MT_W=3, MT_BU=5, MT_HU=6. Codes 0, 4 and 7 are handled as MT_W.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data (rs2).
- `stall`  out  1  core must hold PC and suppress `rf_wen`.
- `rdata`  out  32  aligned, extended load data. Valid in DONE.
- `exc_misaligned`  out  1  misaligned access detected, combinational.
- `exc_fault`  out  1  access timed out. Valid in DONE.
- `mem_req_valid`  out  1  memory request valid.
- `mem_req_ready`  in  1  memory accepts the request.
- `mem_req_we`  out  1  write enable.
- `mem_req_addr`  out  32  `{req_addr[31:2], 2'b00}`.
- `mem_req_wdata`  out  32  lane-replicated store data.
- `mem_req_wstrb`  out  4  byte strobes. Zero for loads.
- `mem_resp_valid`  in  1  response or write acknowledge.
- `mem_resp_data`  in  32  read word.

## Operation
- **States:** IDLE, REQ, WAIT, DONE.
- **Misalignment:** H/HU with `addr[0]`=1, or W with `addr[1:0]`≠0.
  - In IDLE, a misaligned request asserts `exc_misaligned` combinationally.
  - `stall` stays 0 and the state stays IDLE. No memory request is issued.
- **IDLE:**
  - An aligned `req_val` makes `stall`=1 combinationally in the same cycle.
  - Latches `mem_req_*` fields into registers and goes to REQ.
- **REQ:** `mem_req_valid`=1 with the registered fields held. When `mem_req_ready`=1, go to WAIT and clear the timeout counter.
- **WAIT:** the counter increments each cycle.
  - On `mem_resp_valid`, capture the extended data into `rdata` and go to DONE.
  - If the counter reaches `TIMEOUT` with no response, set `exc_fault`, set `rdata`=0 and go to DONE.
  - If the response and the timeout occur in the same cycle, the response wins.
- **DONE:**
  - `stall`=0, and the core commits the instruction this cycle.
  - Next cycle: clear `exc_fault` and go to IDLE.
  - `rdata` holds until the next capture.
- **Stores:** the write acknowledge arrives as `mem_resp_valid`, and its data is ignored.
  - B: wdata = `{4{wdata[7:0]}}`, wstrb = `4'b0001 << addr[1:0]`.
  - H: wdata = `{2{wdata[15:0]}}`, wstrb = `4'b0011 << addr[1:0]`.
  - W: wdata unchanged, wstrb = `4'hF`.
- **Loads:** shift = `resp_data >> (8*addr[1:0])`.
  - B sign-extends `[7:0]`; BU zero-extends `[7:0]`.
  - H sign-extends `[15:0]`; HU zero-extends `[15:0]`.
  - W passes the shifted value unchanged.
- `mem_resp_valid` outside WAIT is ignored.
- While `stall`=1, changes to `req_*` are unsupported. The latched copy is used.

## Timing
- **Reset values:** state=IDLE, `mem_req_valid`=0, `mem_req_we`=0, `mem_req_addr`=0, `mem_req_wdata`=0, `mem_req_wstrb`=0, `rdata`=0, `exc_fault`=0, counter=0.
- **Reset combinational outputs:** `stall`=0 unless IDLE sees an aligned `req_val`. `exc_misaligned` follows its combinational rule.
- Reset asserted mid-access returns to IDLE immediately and drops `mem_req_valid`. A later stray response is ignored.
- **Minimum access:** 4 cycles.
  - C0: IDLE, stall.
  - C1: REQ, ready.
  - C2: WAIT, resp.
  - C3: DONE, `stall`=0.
- Each cycle `mem_req_ready` is low adds one cycle in REQ. Each cycle of response latency adds one cycle in WAIT.
- Back-to-back accesses: the cycle after DONE is IDLE, so a new `req_val` there starts immediately. Throughput is at most one access per 4 cycles.
- `exc_fault` is high for exactly the one DONE cycle.

## Test plan
- **LB with sign extension:** LB at addr `0x103` with resp `0x80FF_1234` → `mem_req_addr`=`0x100`, `wstrb`=0, `rdata`=`0xFFFF_FF80`. LBU at the same address → `rdata`=`0x0000_0080`.
- **SH, lane 2:** SH at `0x206` with wdata `0x1234_ABCD` → `mem_req_wdata`=`0xABCD_ABCD`, `wstrb`=`4'b1100`, `we`=1.
- **Backpressure:** `ready` low for 3 cycles, resp 2 cycles after acceptance → `stall` high for exactly 7 cycles, `mem_req_valid` stable throughout REQ, DONE on cycle 7.
- **Misaligned:** LW at `0x102`, and LH at `0x101` → `exc_misaligned`=1, `stall`=0, no `mem_req_valid` ever.
- **Timeout:** `TIMEOUT`=4, no response → `exc_fault`=1 and `rdata`=0 in DONE after 4 WAIT cycles. A late response is ignored.
- **Reset in WAIT:** reset asserted in WAIT → outputs return to reset values asynchronously. A response arriving after reset is released causes no DONE.
